// File: rtl/branch_hazard_controller.sv
// Purpose : decode-stage branch hazard unit: detects data hazards on branch comparator operands,
//           stalls or forwards as required, flushes after taken branches, keeps perf counters.
// Latency : stall/flush/forward controls are combinational in the same cycle; counters and
//           hazard_error update on the following rising edge.
// Backpr. : stall_f/stall_d hold fetch/decode while a producer is still in EX (or a load is in MEM);
//           there is no other flow control.
//
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   branch_d, pc_src_d       - decode-stage branch type and comparator taken result
//   rs_d, rt_d               - decode-stage source register numbers
//   reg_write_e/m, mem_to_reg_e/m, write_reg_e/m - EX/MEM destination info
//   stall_f, stall_d, flush_e, flush_d            - pipeline control
//   forward_a_d, forward_b_d - select MEM-stage ALU result for comparator operands
//   hazard_error             - sticky flag: stall run exceeded MAX_STALL
//   branch_cnt, taken_cnt, stall_cnt - saturating performance counters

module branch_hazard_controller #(
    parameter int CNT_W     = 16,
    parameter int MAX_STALL = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       branch_d,
    input  logic             pc_src_d,
    input  logic [4:0]       rs_d,
    input  logic [4:0]       rt_d,
    input  logic             reg_write_e,
    input  logic             mem_to_reg_e,
    input  logic [4:0]       write_reg_e,
    input  logic             reg_write_m,
    input  logic             mem_to_reg_m,
    input  logic [4:0]       write_reg_m,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_e,
    output logic             flush_d,
    output logic             forward_a_d,
    output logic             forward_b_d,
    output logic             hazard_error,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    // Run counter must be able to reach MAX_STALL+1 so the watchdog can fire.
    localparam int            RUN_W   = $clog2(MAX_STALL + 2);
    localparam logic [RUN_W-1:0] RUN_TRIP = RUN_W'(MAX_STALL);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_STALL + 1);

    localparam logic [2:0] BR_BEQ  = 3'b001;
    localparam logic [2:0] BR_BNE  = 3'b010;
    localparam logic [2:0] BR_BGEZ = 3'b110;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [RUN_W-1:0] run_cnt;

    logic is_branch;
    logic uses_rt;
    logic active;
    logic ex_rs_match, ex_rt_match;
    logic m_rs_match, m_rt_match;
    logic ex_haz, mem_haz;
    logic stall;
    logic resolved;
    logic taken;

    // mem_to_reg_e is deliberately unused by the decision: any EX producer
    // (ALU or load) is too late for a decode-stage comparison.
    logic unused_ok;
    assign unused_ok = mem_to_reg_e;

    // ---------------------------------------------------------------
    // Hazard detection
    // ---------------------------------------------------------------
    always_comb begin
        is_branch = (branch_d >= BR_BEQ) && (branch_d <= BR_BGEZ);
        uses_rt   = (branch_d == BR_BEQ) || (branch_d == BR_BNE);

        // Outputs are forced low while reset is held, and FLUSH ignores the
        // wrong-path instruction sitting in decode.
        active = is_branch && (state != ST_FLUSH) && !rst;

        // $0 is hardwired zero, so it can never carry a dependency.
        ex_rs_match = (rs_d != 5'd0) && (rs_d == write_reg_e);
        ex_rt_match = (rt_d != 5'd0) && (rt_d == write_reg_e) && uses_rt;
        m_rs_match  = (rs_d != 5'd0) && (rs_d == write_reg_m);
        m_rt_match  = (rt_d != 5'd0) && (rt_d == write_reg_m) && uses_rt;

        ex_haz  = reg_write_e && (ex_rs_match || ex_rt_match);
        // A load in MEM has no data yet; an ALU result in MEM is forwarded instead.
        mem_haz = reg_write_m && mem_to_reg_m && (m_rs_match || m_rt_match);

        stall    = active && (ex_haz || mem_haz);
        resolved = active && !stall;
        taken    = resolved && pc_src_d;
    end

    // ---------------------------------------------------------------
    // Control / forwarding outputs and next state
    // ---------------------------------------------------------------
    always_comb begin
        stall_f     = stall;
        stall_d     = stall;
        flush_e     = stall;
        flush_d     = taken;
        forward_a_d = active && reg_write_m && !mem_to_reg_m && m_rs_match;
        forward_b_d = active && reg_write_m && !mem_to_reg_m && m_rt_match;

        state_nxt = ST_RUN;
        if (stall) begin
            state_nxt = ST_STALL;
        end else if (taken) begin
            state_nxt = ST_FLUSH;
        end
    end

    // ---------------------------------------------------------------
    // State, watchdog and counters
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_RUN;
            run_cnt      <= '0;
            hazard_error <= 1'b0;
        end else begin
            state <= state_nxt;
            if (stall) begin
                if (run_cnt != RUN_MAX) begin
                    run_cnt <= run_cnt + RUN_W'(1);
                end
                // This stall cycle takes the run to MAX_STALL+1.
                if (run_cnt == RUN_TRIP) begin
                    hazard_error <= 1'b1;
                end
            end else begin
                run_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt <= '0;
            taken_cnt  <= '0;
            stall_cnt  <= '0;
        end else begin
            if (resolved && (branch_cnt != '1)) begin
                branch_cnt <= branch_cnt + CNT_W'(1);
            end
            if (taken && (taken_cnt != '1)) begin
                taken_cnt <= taken_cnt + CNT_W'(1);
            end
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule
